// File: rtl/knn_vote_accum_if.sv
// knn_vote_accum_if: control, neighbour-stream and result bundle of the k-NN vote block.
// master = producer/consumer side, slave = vote accumulator side.
interface knn_vote_accum_if #(
    parameter int NUM_CLASSES = 4,
    parameter int K_MAX       = 15
);
    localparam int LBL_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
    localparam int KW    = $clog2(K_MAX + 1);

    logic             start;
    logic [KW-1:0]    k_value;
    logic             busy;
    logic             nb_valid;
    logic             nb_ready;
    logic [LBL_W-1:0] nb_label;
    logic             res_valid;
    logic             res_ready;
    logic [LBL_W-1:0] res_class;
    logic [KW-1:0]    res_votes;
    logic             res_tie;
    logic             res_err;

    modport master (
        output start, k_value, nb_valid, nb_label, res_ready,
        input  busy, nb_ready, res_valid, res_class, res_votes, res_tie, res_err
    );

    modport slave (
        input  start, k_value, nb_valid, nb_label, res_ready,
        output busy, nb_ready, res_valid, res_class, res_votes, res_tie, res_err
    );
endinterface

// File: rtl/knn_vote_accum.sv
// knn_vote_accum: majority vote over k nearest-first neighbour labels, nearest wins ties.
// Ports: clk, rst (sync, active high), bus (knn_vote_accum_if.slave).
module knn_vote_accum #(
    parameter int NUM_CLASSES = 4,
    parameter int K_MAX       = 15
) (
    input  logic                clk,
    input  logic                rst,
    knn_vote_accum_if.slave     bus
);
    localparam int LBL_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int SW    = LBL_W + 1;
    localparam logic [KW-1:0] KMAX_L = KW'(K_MAX);
    localparam logic [SW-1:0] NCLS   = SW'(NUM_CLASSES);

    typedef enum logic [1:0] {IDLE, COLLECT, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    beat_q, beat_d;
    logic             err_q, err_d;
    logic [KW-1:0]    cnt_q  [NUM_CLASSES];
    logic [KW-1:0]    cnt_d  [NUM_CLASSES];
    logic [KW-1:0]    fidx_q [NUM_CLASSES];
    logic [KW-1:0]    fidx_d [NUM_CLASSES];
    logic [SW-1:0]    scan_q, scan_d;
    logic [LBL_W-1:0] best_q, best_d;
    logic [KW-1:0]    bcnt_q, bcnt_d;
    logic [KW-1:0]    bfidx_q, bfidx_d;
    logic             btie_q, btie_d;
    logic [LBL_W-1:0] rcls_q, rcls_d;
    logic [KW-1:0]    rvot_q, rvot_d;
    logic             rtie_q, rtie_d;
    logic             rerr_q, rerr_d;

    logic             accept;
    logic             lbl_ok;
    logic             k_ok;
    logic [LBL_W-1:0] sidx;

    assign accept = (state_q == COLLECT) && bus.nb_valid;
    assign lbl_ok = {1'b0, bus.nb_label} < NCLS;
    assign k_ok   = (bus.k_value != '0) && (bus.k_value <= KMAX_L);
    assign sidx   = scan_q[LBL_W-1:0];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        fidx_d  = fidx_q;
        scan_d  = scan_q;
        best_d  = best_q;
        bcnt_d  = bcnt_q;
        bfidx_d = bfidx_q;
        btie_d  = btie_q;
        rcls_d  = rcls_q;
        rvot_d  = rvot_q;
        rtie_d  = rtie_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && k_ok) begin
                    k_d     = bus.k_value;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    scan_d  = '0;
                    best_d  = '0;
                    bcnt_d  = '0;
                    bfidx_d = '0;
                    btie_d  = 1'b0;
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        cnt_d[c]  = '0;
                        fidx_d[c] = '0;
                    end
                    state_d = COLLECT;
                end else if (bus.start) begin
                    rcls_d  = '0;
                    rvot_d  = '0;
                    rtie_d  = 1'b0;
                    rerr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (lbl_ok) begin
                        cnt_d[bus.nb_label] = cnt_q[bus.nb_label] + KW'(1);
                        if (cnt_q[bus.nb_label] == '0) begin
                            fidx_d[bus.nb_label] = beat_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    beat_d = beat_q + KW'(1);
                    if (beat_d == k_q) begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // One extra cycle after the last class to register the result.
                if (scan_q == NCLS) begin
                    if (bcnt_q == '0) begin
                        rcls_d = '0;
                        rvot_d = '0;
                        rtie_d = 1'b0;
                        rerr_d = 1'b1;
                    end else begin
                        rcls_d = best_q;
                        rvot_d = bcnt_q;
                        rtie_d = btie_q;
                        rerr_d = err_q;
                    end
                    state_d = DONE;
                end else begin
                    if (cnt_q[sidx] > bcnt_q) begin
                        best_d  = sidx;
                        bcnt_d  = cnt_q[sidx];
                        bfidx_d = fidx_q[sidx];
                        btie_d  = 1'b0;
                    end else if ((cnt_q[sidx] == bcnt_q) && (cnt_q[sidx] != '0)) begin
                        btie_d = 1'b1;
                        // Tied: the class seen first in the stream is nearer.
                        if (fidx_q[sidx] < bfidx_q) begin
                            best_d  = sidx;
                            bfidx_d = fidx_q[sidx];
                        end
                    end
                    scan_d = scan_q + SW'(1);
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            scan_q  <= '0;
            best_q  <= '0;
            bcnt_q  <= '0;
            bfidx_q <= '0;
            btie_q  <= 1'b0;
            rcls_q  <= '0;
            rvot_q  <= '0;
            rtie_q  <= 1'b0;
            rerr_q  <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt_q[c]  <= '0;
                fidx_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            scan_q  <= scan_d;
            best_q  <= best_d;
            bcnt_q  <= bcnt_d;
            bfidx_q <= bfidx_d;
            btie_q  <= btie_d;
            rcls_q  <= rcls_d;
            rvot_q  <= rvot_d;
            rtie_q  <= rtie_d;
            rerr_q  <= rerr_d;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                cnt_q[c]  <= cnt_d[c];
                fidx_q[c] <= fidx_d[c];
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.nb_ready  = (state_q == COLLECT);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_class = rcls_q;
    assign bus.res_votes = rvot_q;
    assign bus.res_tie   = rtie_q;
    assign bus.res_err   = rerr_q;
endmodule

// File: tb/tb_knn_vote_accum.sv
// tb_knn_vote_accum: directed and random votes against a counting reference model.
// Two instances: 4 classes (main) and 5 classes (out-of-range labels).
module tb_knn_vote_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    knn_vote_accum_if #(.NUM_CLASSES(4), .K_MAX(15)) ifc ();
    knn_vote_accum_if #(.NUM_CLASSES(5), .K_MAX(15)) ifc5 ();

    knn_vote_accum #(.NUM_CLASSES(4), .K_MAX(15)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    knn_vote_accum #(.NUM_CLASSES(5), .K_MAX(15)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (ifc5)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain histogram; winner is the earliest label in the
    // stream whose class holds the maximum count.
    function automatic void model(input int lbl[$], input int nc,
                                  output int cls, output int votes,
                                  output int tie, output int err);
        int  cnt[16];
        int  ntied;
        bit  found;
        cnt   = '{default: 0};
        err   = 0;
        votes = 0;
        ntied = 0;
        cls   = 0;
        found = 0;
        foreach (lbl[i]) begin
            if (lbl[i] < nc) cnt[lbl[i]]++;
            else err = 1;
        end
        foreach (cnt[c]) if (cnt[c] > votes) votes = cnt[c];
        foreach (cnt[c]) if (votes > 0 && cnt[c] == votes) ntied++;
        tie = (ntied > 1) ? 1 : 0;
        if (votes == 0) begin
            err = 1;
        end else begin
            foreach (lbl[i]) begin
                if (!found && lbl[i] < nc && cnt[lbl[i]] == votes) begin
                    cls   = lbl[i];
                    found = 1;
                end
            end
        end
    endfunction

    task automatic run_vote(int k, int lbl[$], int gap, int hold, bit poke);
        int ec, ev, et, ee;
        int n;
        model(lbl, 4, ec, ev, et, ee);
        ifc.start   = 1'b1;
        ifc.k_value = 4'(k);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("busy_after_start", 32'(ifc.busy), 1);
        foreach (lbl[i]) begin
            repeat ($urandom_range(0, gap)) begin
                ifc.nb_valid = 1'b0;
                @(posedge clk); #1;
                chk("nb_ready_gap", 32'(ifc.nb_ready), 1);
            end
            ifc.nb_valid = 1'b1;
            ifc.nb_label = 2'(lbl[i]);
            if (poke && i == 1) begin
                ifc.start   = 1'b1;
                ifc.k_value = 4'd1;
            end
            chk("nb_ready", 32'(ifc.nb_ready), 1);
            @(posedge clk); #1;
            ifc.nb_valid = 1'b0;
            ifc.start    = 1'b0;
        end
        chk("nb_ready_off", 32'(ifc.nb_ready), 0);
        n = 0;
        while (!ifc.res_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 5);
        chk("res_class", 32'(ifc.res_class), ec);
        chk("res_votes", 32'(ifc.res_votes), ev);
        chk("res_tie", 32'(ifc.res_tie), et);
        chk("res_err", 32'(ifc.res_err), ee);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(ifc.res_valid), 1);
            chk("hold_class", 32'(ifc.res_class), ec);
            chk("hold_votes", 32'(ifc.res_votes), ev);
            chk("hold_tie", 32'(ifc.res_tie), et);
        end
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        chk("release_valid", 32'(ifc.res_valid), 0);
        chk("release_busy", 32'(ifc.busy), 0);
    endtask

    task automatic run5(int k, int lbl[$]);
        int ec, ev, et, ee;
        int n;
        model(lbl, 5, ec, ev, et, ee);
        ifc5.start   = 1'b1;
        ifc5.k_value = 4'(k);
        @(posedge clk); #1;
        ifc5.start = 1'b0;
        foreach (lbl[i]) begin
            ifc5.nb_valid = 1'b1;
            ifc5.nb_label = 3'(lbl[i]);
            chk("nb_ready5", 32'(ifc5.nb_ready), 1);
            @(posedge clk); #1;
        end
        ifc5.nb_valid = 1'b0;
        n = 0;
        while (!ifc5.res_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency5", n, 6);
        chk("res_class5", 32'(ifc5.res_class), ec);
        chk("res_votes5", 32'(ifc5.res_votes), ev);
        chk("res_tie5", 32'(ifc5.res_tie), et);
        chk("res_err5", 32'(ifc5.res_err), ee);
        ifc5.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc5.res_ready = 1'b0;
        chk("release_valid5", 32'(ifc5.res_valid), 0);
    endtask

    initial begin
        int k;
        int lbl[$];
        ifc.start      = 1'b0;
        ifc.k_value    = '0;
        ifc.nb_valid   = 1'b0;
        ifc.nb_label   = '0;
        ifc.res_ready  = 1'b0;
        ifc5.start     = 1'b0;
        ifc5.k_value   = '0;
        ifc5.nb_valid  = 1'b0;
        ifc5.nb_label  = '0;
        ifc5.res_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_nb_ready", 32'(ifc.nb_ready), 0);
        chk("rst_res_valid", 32'(ifc.res_valid), 0);
        chk("rst_res_class", 32'(ifc.res_class), 0);
        chk("rst_res_votes", 32'(ifc.res_votes), 0);
        chk("rst_res_tie", 32'(ifc.res_tie), 0);
        chk("rst_res_err", 32'(ifc.res_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_vote(3, '{2, 1, 2}, 0, 0, 0);
        run_vote(5, '{0, 1, 1, 2, 2}, 1, 0, 0);
        run_vote(5, '{3, 1, 1, 3, 0}, 1, 0, 0);

        ifc.start   = 1'b1;
        ifc.k_value = 4'd0;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("k0_nb_ready", 32'(ifc.nb_ready), 0);
        chk("k0_res_valid", 32'(ifc.res_valid), 1);
        chk("k0_res_err", 32'(ifc.res_err), 1);
        chk("k0_res_class", 32'(ifc.res_class), 0);
        chk("k0_res_votes", 32'(ifc.res_votes), 0);
        chk("k0_res_tie", 32'(ifc.res_tie), 0);
        ifc.res_ready = 1'b1;
        @(posedge clk); #1;
        ifc.res_ready = 1'b0;
        chk("k0_release", 32'(ifc.res_valid), 0);

        run5(3, '{1, 5, 1});
        run5(2, '{5, 6});

        run_vote(4, '{0, 2, 2, 1}, 2, 10, 0);
        run_vote(4, '{3, 0, 3, 3}, 1, 0, 1);

        ifc.start   = 1'b1;
        ifc.k_value = 4'd4;
        @(posedge clk); #1;
        ifc.start    = 1'b0;
        ifc.nb_valid = 1'b1;
        ifc.nb_label = 2'd3;
        repeat (2) @(posedge clk);
        #1;
        ifc.nb_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(ifc.busy), 0);
        chk("abort_nb_ready", 32'(ifc.nb_ready), 0);
        chk("abort_res_valid", 32'(ifc.res_valid), 0);
        run_vote(1, '{3}, 0, 0, 0);

        ifc.start   = 1'b1;
        ifc.k_value = 4'd2;
        @(posedge clk); #1;
        ifc.start    = 1'b0;
        ifc.nb_valid = 1'b1;
        ifc.nb_label = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        ifc.nb_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("done_before_rst", 32'(ifc.res_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("done_rst_valid", 32'(ifc.res_valid), 0);
        chk("done_rst_class", 32'(ifc.res_class), 0);
        chk("done_rst_votes", 32'(ifc.res_votes), 0);

        lbl = {};
        repeat (15) lbl.push_back(1);
        run_vote(15, lbl, 3, 0, 0);

        repeat (12) begin
            k = $urandom_range(1, 15);
            lbl = {};
            repeat (k) lbl.push_back($urandom_range(0, 3));
            run_vote(k, lbl, 2, $urandom_range(0, 2), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
